// File: rtl/om_est_pkg.sv
// Shared definitions for the Oerder-Meyr timing estimator.
//  - Default widths and block length.
//  - acc_w(): width of the signed phase accumulators.
//  - atan_tab(): atan(2^-i) in 16-bit binary-angle units (65536 = 2*pi), i = 0..15.
//  - FSM state encoding used by the estimator top.
package om_est_pkg;

    localparam int unsigned DW_DEF          = 16;
    localparam int unsigned EPS_W_DEF       = 16;
    localparam int unsigned L_SYM_DEF       = 64;
    localparam int unsigned CORDIC_ITER_DEF = 14;

    // Power term is 2*DW bits. Two more bits cover sign and the +/- rotation,
    // and log2(L_SYM) bits cover the sum over one block.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned l_sym);
        return 2 * dw + 2 + $clog2(l_sym);
    endfunction

    function automatic logic [15:0] atan_tab(input logic [3:0] i);
        logic [15:0] a;
        case (i)
            4'd0:    a = 16'd8192;
            4'd1:    a = 16'd4836;
            4'd2:    a = 16'd2555;
            4'd3:    a = 16'd1297;
            4'd4:    a = 16'd651;
            4'd5:    a = 16'd326;
            4'd6:    a = 16'd163;
            4'd7:    a = 16'd81;
            4'd8:    a = 16'd41;
            4'd9:    a = 16'd20;
            4'd10:   a = 16'd10;
            4'd11:   a = 16'd5;
            4'd12:   a = 16'd3;
            4'd13:   a = 16'd1;
            4'd14:   a = 16'd1;
            default: a = 16'd0;
        endcase
        return a;
    endfunction

    typedef logic [1:0] om_state_t;

    localparam om_state_t StIdle   = 2'd0;
    localparam om_state_t StPrerot = 2'd1;
    localparam om_state_t StIter   = 2'd2;
    localparam om_state_t StDone   = 2'd3;

endpackage

// File: rtl/cordic_vec.sv
// Iterative CORDIC vectoring core. It rotates (x, y) toward the positive x axis
// and accumulates the applied rotation into z, so z ends as z_in + atan2(y_in, x_in).
// The caller must supply x_in >= 0; quadrant handling lives outside this core.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  start        one-cycle pulse that loads x_in/y_in/z_in and starts ITER iterations
//  x_in, y_in   signed vector, W bits; W must absorb the ~1.65 CORDIC gain
//  z_in         initial angle, AW-bit binary angle (2^AW = 2*pi)
//  angle        accumulated angle, valid when done pulses, held afterwards
//  done         one-cycle pulse after the last iteration
//  busy         high while iterating
module cordic_vec
    import om_est_pkg::*;
#(
    parameter int unsigned W    = 42,
    parameter int unsigned AW   = 16,
    parameter int unsigned ITER = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic [AW-1:0]       z_in,
    output logic [AW-1:0]       angle,
    output logic                done,
    output logic                busy
);

    logic signed [W-1:0] x_q, y_q, x_d, y_d, xs, ys;
    logic [AW-1:0]       z_q, z_d, at;
    logic [3:0]          i_q;
    logic                run_q, done_q;

    always_comb begin
        xs = x_q >>> i_q;
        ys = y_q >>> i_q;
        // Table is 16-bit binary angle; rescale to AW bits.
        at = AW'({atan_tab(i_q), 16'h0000} >> (32 - AW));
        if (!y_q[W-1]) begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            z_d = z_q + at;
        end else begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            z_d = z_q - at;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                x_q   <= x_in;
                y_q   <= y_in;
                z_q   <= z_in;
                i_q   <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                x_q <= x_d;
                y_q <= y_d;
                z_q <= z_d;
                i_q <= i_q + 4'd1;
                if (i_q == 4'(ITER - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign angle = z_q;
    assign done  = done_q;
    assign busy  = run_q;

endmodule

// File: rtl/om_timing_estimator.sv
// Oerder-Meyr feedforward symbol-timing estimator for 4x-oversampled I/Q.
// Forms X = sum |x[n]|^2 * e^(-j*pi*n/2) over L_SYM symbols and outputs
// epslion = -arg(X)/(2*pi) as an unsigned fraction of one symbol period.
// Ports:
//  clk, rst_n           clock, asynchronous active-low reset
//  clear                sync; abort current block, restart phase counter
//  sample_i, sample_q   signed DW-bit I/Q samples
//  sample_vld           sample valid, at most one per clock
//  epslion              timing estimate, unsigned Q0.EPS_W, held between updates
//  eps_vld              one-cycle pulse when epslion updates
//  busy                 high while the CORDIC solve is in progress
module om_timing_estimator
    import om_est_pkg::*;
#(
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned L_SYM       = L_SYM_DEF,
    parameter int unsigned CORDIC_ITER = CORDIC_ITER_DEF,
    parameter int unsigned EPS_W       = EPS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DW-1:0]    sample_i,
    input  logic [DW-1:0]    sample_q,
    input  logic             sample_vld,
    output logic [EPS_W-1:0] epslion,
    output logic             eps_vld,
    output logic             busy
);

    localparam int unsigned ACC_W = acc_w(DW, L_SYM);
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned CNT_W = $clog2(4 * L_SYM);
    // Headroom for negation of the most negative value and the CORDIC gain.
    localparam int unsigned CW    = ACC_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4 * L_SYM - 1);

    // ---------------- Stage 1: instantaneous power ----------------
    logic signed [PW-1:0] si_x, sq_x, isq, qsq;
    logic [PW-1:0]        p_d, p_q;
    logic                 p_vld_q;

    assign si_x = PW'($signed(sample_i));
    assign sq_x = PW'($signed(sample_q));
    assign isq  = si_x * si_x;
    assign qsq  = sq_x * sq_x;
    assign p_d  = $unsigned(isq) + $unsigned(qsq);

    // ---------------- Stage 2: phase rotation and accumulation ----------------
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q, acc_re_nxt, acc_im_nxt, p_ext;
    logic signed [ACC_W-1:0] solve_re_q, solve_im_q;
    logic                    blk_end;

    // Multiplier-free rotation by e^(-j*pi*k/2); k is the low two count bits.
    always_comb begin
        p_ext      = $signed({{(ACC_W - PW){1'b0}}, p_q});
        acc_re_nxt = acc_re_q;
        acc_im_nxt = acc_im_q;
        case (cnt_q[1:0])
            2'd0:    acc_re_nxt = acc_re_q + p_ext;
            2'd1:    acc_im_nxt = acc_im_q - p_ext;
            2'd2:    acc_re_nxt = acc_re_q - p_ext;
            default: acc_im_nxt = acc_im_q + p_ext;
        endcase
        blk_end = p_vld_q && !clear && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            p_vld_q    <= 1'b0;
            cnt_q      <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            solve_re_q <= '0;
            solve_im_q <= '0;
        end else begin
            // A sample arriving together with clear is dropped.
            p_vld_q <= sample_vld && !clear;
            if (sample_vld) begin
                p_q <= p_d;
            end
            if (clear) begin
                cnt_q    <= '0;
                acc_re_q <= '0;
                acc_im_q <= '0;
            end else if (p_vld_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (blk_end) begin
                    // Hand the finished block to the solver; the next sample
                    // starts a fresh block with no gap.
                    solve_re_q <= acc_re_nxt;
                    solve_im_q <= acc_im_nxt;
                    acc_re_q   <= '0;
                    acc_im_q   <= '0;
                end else begin
                    acc_re_q <= acc_re_nxt;
                    acc_im_q <= acc_im_nxt;
                end
            end
        end
    end

    // ---------------- Solver FSM ----------------
    om_state_t            state_q, state_d;
    logic                 cordic_start, cordic_done, cordic_busy;
    logic [EPS_W-1:0]     cordic_angle, cz;
    logic signed [CW-1:0] re_x, im_x, cx, cy;
    logic                 solve_zero;

    assign re_x       = CW'(solve_re_q);
    assign im_x       = CW'(solve_im_q);
    assign solve_zero = (solve_re_q == '0) && (solve_im_q == '0);

    // Left half-plane: rotate by pi so the core sees x >= 0.
    always_comb begin
        if (solve_re_q[ACC_W-1]) begin
            cx = -re_x;
            cy = -im_x;
            cz = {1'b1, {(EPS_W - 1){1'b0}}};
        end else begin
            cx = re_x;
            cy = im_x;
            cz = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        cordic_start = 1'b0;
        case (state_q)
            StIdle:   if (blk_end) state_d = StPrerot;
            StPrerot: begin
                cordic_start = 1'b1;
                state_d      = StIter;
            end
            StIter:   if (cordic_done) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            epslion <= '0;
            eps_vld <= 1'b0;
        end else begin
            state_q <= state_d;
            eps_vld <= (state_q == StDone);
            if (state_q == StDone) begin
                // A zero vector has no defined angle; report zero offset.
                epslion <= solve_zero ? '0 : -cordic_angle;
            end
        end
    end

    assign busy = (state_q == StPrerot) || (state_q == StIter) || cordic_busy;

    cordic_vec #(
        .W    (CW),
        .AW   (EPS_W),
        .ITER (CORDIC_ITER)
    ) u_cordic (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cordic_start),
        .x_in  (cx),
        .y_in  (cy),
        .z_in  (cz),
        .angle (cordic_angle),
        .done  (cordic_done),
        .busy  (cordic_busy)
    );

endmodule

// File: tb/tb_om_timing_estimator.sv
module tb_om_timing_estimator;

    localparam int unsigned ITER = 14;
    localparam int          LAT  = ITER + 4;

    logic        clk = 1'b0;
    logic        rst_n, clear, sample_vld;
    logic [15:0] sample_i, sample_q, epslion;
    logic        eps_vld, busy;

    int cyc      = 0;
    int total    = 0;
    int passed   = 0;
    int last_cyc = 0;

    logic [15:0] ev_val[$];
    int          ev_cyc[$];

    om_timing_estimator #(
        .DW          (16),
        .L_SYM       (64),
        .CORDIC_ITER (ITER),
        .EPS_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sample_i   (sample_i),
        .sample_q   (sample_q),
        .sample_vld (sample_vld),
        .epslion    (epslion),
        .eps_vld    (eps_vld),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every estimate; a block ending while the solver is busy is an error.
    always @(negedge clk) begin
        if (eps_vld) begin
            ev_val.push_back(epslion);
            ev_cyc.push_back(cyc);
        end
        if (rst_n && dut.blk_end && busy) begin
            total++;
            $display("FAIL blk_end_while_busy at cycle %0d", cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout after %0d cycles", cyc);
        $fatal(1, "timeout");
    end

    function automatic int wdist(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = a - b;
        return d[15] ? 65536 - int'(d) : int'(d);
    endfunction

    task automatic send(input logic [15:0] si, input logic [15:0] sq, input logic clr);
        sample_i   = si;
        sample_q   = sq;
        sample_vld = 1'b1;
        clear      = clr;
        @(posedge clk);
        #1;
        sample_vld = 1'b0;
        clear      = 1'b0;
        last_cyc   = cyc;
    endtask

    // Energy (i=1000) only where n%4 == k; k<0 gives an all-zero block.
    task automatic send_block(input int k, input int n);
        for (int j = 0; j < n; j++) begin
            send(((j % 4) == k) ? 16'd1000 : 16'd0, 16'd0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_events();
        ev_val.delete();
        ev_cyc.delete();
    endtask

    task automatic test_reset();
        total++;
        if (epslion !== 16'h0000) $display("FAIL reset_eps got %h want 0000", epslion);
        else passed++;
        total++;
        if (eps_vld !== 1'b0) $display("FAIL reset_eps_vld got %b want 0", eps_vld);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_phase();
        logic [15:0] exp_v[4];
        exp_v = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
        for (int k = 0; k < 4; k++) begin
            clr_events();
            send_block(k, 256);
            idle(LAT + 6);
            total++;
            if (ev_val.size() !== 1) $display("FAIL phase%0d_count got %0d want 1", k, ev_val.size());
            else passed++;
            if (ev_val.size() > 0) begin
                total++;
                if (wdist(ev_val[0], exp_v[k]) > 2)
                    $display("FAIL phase%0d_eps got %h want %h +/-2", k, ev_val[0], exp_v[k]);
                else passed++;
                total++;
                if ((ev_cyc[0] - last_cyc) !== LAT)
                    $display("FAIL phase%0d_latency got %0d want %0d", k, ev_cyc[0] - last_cyc, LAT);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int e0, e1;
        clr_events();
        send_block(0, 256);
        e0 = last_cyc;
        send_block(1, 256);
        e1 = last_cyc;
        idle(LAT + 6);
        total++;
        if (ev_val.size() !== 2) $display("FAIL b2b_count got %0d want 2", ev_val.size());
        else passed++;
        if (ev_val.size() >= 2) begin
            total++;
            if (wdist(ev_val[0], 16'h0000) > 2) $display("FAIL b2b_eps0 got %h want 0000 +/-2", ev_val[0]);
            else passed++;
            total++;
            if (wdist(ev_val[1], 16'h4000) > 2) $display("FAIL b2b_eps1 got %h want 4000 +/-2", ev_val[1]);
            else passed++;
            total++;
            if ((ev_cyc[0] - e0) !== LAT) $display("FAIL b2b_lat0 got %0d want %0d", ev_cyc[0] - e0, LAT);
            else passed++;
            total++;
            if ((ev_cyc[1] - e1) !== LAT) $display("FAIL b2b_lat1 got %0d want %0d", ev_cyc[1] - e1, LAT);
            else passed++;
        end
    endtask

    task automatic test_zero_block();
        int e0;
        clr_events();
        send_block(-1, 256);
        e0 = last_cyc;
        idle(5);
        total++;
        if (busy !== 1'b1) $display("FAIL zero_busy_mid got %b want 1", busy);
        else passed++;
        idle(12);
        total++;
        if (busy !== 1'b0) $display("FAIL zero_busy_done got %b want 0", busy);
        else passed++;
        idle(6);
        total++;
        if (ev_val.size() !== 1) $display("FAIL zero_count got %0d want 1", ev_val.size());
        else passed++;
        if (ev_val.size() > 0) begin
            total++;
            if (ev_val[0] !== 16'h0000) $display("FAIL zero_eps got %h want 0000", ev_val[0]);
            else passed++;
            total++;
            if ((ev_cyc[0] - e0) !== LAT) $display("FAIL zero_latency got %0d want %0d", ev_cyc[0] - e0, LAT);
            else passed++;
        end
    endtask

    task automatic test_clear();
        clr_events();
        for (int j = 0; j < 100; j++) send(((j % 4) == 0) ? 16'd1000 : 16'd0, 16'd0, 1'b0);
        send(16'd1000, 16'd0, 1'b1);  // sample 100, dropped by clear
        for (int j = 0; j < 255; j++) send(((j % 4) == 1) ? 16'd1000 : 16'd0, 16'd0, 1'b0);
        idle(LAT + 6);
        total++;
        if (ev_val.size() !== 0) $display("FAIL clear_early_end got %0d estimates want 0", ev_val.size());
        else passed++;
        send(16'd0, 16'd0, 1'b0);  // 256th sample after clear
        idle(LAT + 6);
        total++;
        if (ev_val.size() !== 1) $display("FAIL clear_count got %0d want 1", ev_val.size());
        else passed++;
        if (ev_val.size() > 0) begin
            total++;
            if (wdist(ev_val[ev_val.size() - 1], 16'h4000) > 2)
                $display("FAIL clear_eps got %h want 4000 +/-2", ev_val[ev_val.size() - 1]);
            else passed++;
            total++;
            if ((ev_cyc[ev_cyc.size() - 1] - last_cyc) !== LAT)
                $display("FAIL clear_latency got %0d want %0d", ev_cyc[ev_cyc.size() - 1] - last_cyc, LAT);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_solve();
        clr_events();
        send_block(0, 256);
        idle(6);
        total++;
        if (busy !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", busy);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (epslion !== 16'h0000) $display("FAIL rstmid_eps got %h want 0000", epslion);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy);
        else passed++;
        total++;
        if (eps_vld !== 1'b0) $display("FAIL rstmid_eps_vld got %b want 0", eps_vld);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(LAT + 10);
        total++;
        if (ev_val.size() !== 0) $display("FAIL rstmid_no_pulse got %0d estimates want 0", ev_val.size());
        else passed++;
        send_block(2, 256);
        idle(LAT + 6);
        total++;
        if (ev_val.size() !== 1) $display("FAIL rstmid_recover_count got %0d want 1", ev_val.size());
        else passed++;
        if (ev_val.size() > 0) begin
            total++;
            if (wdist(ev_val[0], 16'h8000) > 2)
                $display("FAIL rstmid_recover_eps got %h want 8000 +/-2", ev_val[0]);
            else passed++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        sample_vld = 1'b0;
        sample_i   = 16'd0;
        sample_q   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        test_reset();
        test_phase();
        test_back_to_back();
        test_zero_block();
        test_clear();
        test_reset_mid_solve();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
